// File: rtl/pipe_stage_register_if.sv
// Handshake/bus bundle for pipe_stage_register: pipeline control inputs, the entry
// being loaded, the last-stage entry and the bubble counter.
interface pipe_stage_register_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              insert_bubble;
  logic              valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic              cnt_clear;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall, flush, insert_bubble, valid_in, ctrl_in, data_in, cnt_clear,
    input  valid_out, ctrl_out, data_out, bubble_cnt
  );

  modport slave (
    input  stall, flush, insert_bubble, valid_in, ctrl_in, data_in, cnt_clear,
    output valid_out, ctrl_out, data_out, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_register.sv
// Chain of DEPTH pipeline registers carrying a control and a data bundle, with
// flush/stall/bubble handling and a saturating count of empty output cycles.
module pipe_stage_register #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipe_stage_register_if.slave  bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_register: DEPTH must be in 1..4");
  end

  logic              valid_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic              load_valid;

  // A bubble or an invalid incoming entry must never carry live control bits.
  assign load_valid = bus.valid_in & ~bus.insert_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
      end
    end else if (bus.flush) begin
      // Flush kills control even under stall, but data still shifts.
      valid_q[0] <= 1'b0;
      ctrl_q[0]  <= '0;
      data_q[0]  <= bus.data_in;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= data_q[k-1];
      end
    end else if (!bus.stall) begin
      valid_q[0] <= load_valid;
      ctrl_q[0]  <= load_valid ? bus.ctrl_in : '0;
      data_q[0]  <= bus.data_in;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clear) begin
      cnt_q <= '0;
    end else if (!valid_q[DEPTH-1] && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.valid_out  = valid_q[DEPTH-1];
  assign bus.ctrl_out   = ctrl_q[DEPTH-1];
  assign bus.data_out   = data_q[DEPTH-1];
  assign bus.bubble_cnt = cnt_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_dead_ctrl_chk
    a_dead_ctrl_zero: assert property (
      @(posedge clk) disable iff (reset) !valid_q[g] |-> (ctrl_q[g] == '0)
    );
  end

endmodule

// File: tb/tb_pipe_stage_register.sv
// Drives DEPTH=1/2/3 instances with one shared directed stream and checks them
// against a queue-based model every cycle, plus hand-computed spot checks.
module tb_pipe_stage_register;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } entry_t;
  typedef entry_t eq_t [$];

  logic              clk;
  logic              reset;
  logic              tb_stall, tb_flush, tb_bubble, tb_valid, tb_clear;
  logic [CTRL_W-1:0] tb_ctrl;
  logic [DATA_W-1:0] tb_data;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;

  eq_t q1, q2, q3;
  int  mcnt1, mcnt2, mcnt3;

  pipe_stage_register_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) if1 ();
  pipe_stage_register_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) if2 ();
  pipe_stage_register_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) if3 ();

  assign if1.stall = tb_stall;  assign if2.stall = tb_stall;  assign if3.stall = tb_stall;
  assign if1.flush = tb_flush;  assign if2.flush = tb_flush;  assign if3.flush = tb_flush;
  assign if1.insert_bubble = tb_bubble;
  assign if2.insert_bubble = tb_bubble;
  assign if3.insert_bubble = tb_bubble;
  assign if1.valid_in = tb_valid;  assign if2.valid_in = tb_valid;  assign if3.valid_in = tb_valid;
  assign if1.ctrl_in = tb_ctrl;    assign if2.ctrl_in = tb_ctrl;    assign if3.ctrl_in = tb_ctrl;
  assign if1.data_in = tb_data;    assign if2.data_in = tb_data;    assign if3.data_in = tb_data;
  assign if1.cnt_clear = tb_clear; assign if2.cnt_clear = tb_clear; assign if3.cnt_clear = tb_clear;

  pipe_stage_register #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(1), .CNT_W(CNT_W)) u_d1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  pipe_stage_register #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(2), .CNT_W(CNT_W)) u_d2 (
    .clk(clk), .reset(reset), .bus(if2)
  );
  pipe_stage_register #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(3), .CNT_W(CNT_W)) u_d3 (
    .clk(clk), .reset(reset), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic eq_t zero_queue(int depth);
    eq_t r;
    for (int i = 0; i < depth; i++) r.push_back('0);
    return r;
  endfunction

  // Newest entry at the front, output entry at the back.
  function automatic eq_t model_step(eq_t q);
    eq_t    r = q;
    entry_t e;
    if (tb_stall && !tb_flush) return r;
    e.v = tb_valid && !tb_bubble && !tb_flush;
    e.c = e.v ? tb_ctrl : '0;
    e.d = tb_data;
    if (tb_flush) begin
      for (int i = 0; i < r.size(); i++) begin
        r[i].v = 1'b0;
        r[i].c = '0;
      end
    end
    r.push_front(e);
    r.delete(r.size() - 1);
    return r;
  endfunction

  function automatic int next_cnt(int cnt, logic out_valid);
    if (tb_clear) return 0;
    if (!out_valid && cnt < (1 << CNT_W) - 1) return cnt + 1;
    return cnt;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q1 = zero_queue(1);
      q2 = zero_queue(2);
      q3 = zero_queue(3);
      mcnt1 = 0;
      mcnt2 = 0;
      mcnt3 = 0;
    end else begin
      mcnt1 = next_cnt(mcnt1, q1[q1.size()-1].v);
      mcnt2 = next_cnt(mcnt2, q2[q2.size()-1].v);
      mcnt3 = next_cnt(mcnt3, q3[q3.size()-1].v);
      q1 = model_step(q1);
      q2 = model_step(q2);
      q3 = model_step(q3);
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("d1_valid", if1.valid_out,  q1[q1.size()-1].v);
      checkOutput("d1_ctrl",  if1.ctrl_out,   q1[q1.size()-1].c);
      checkOutput("d1_data",  if1.data_out,   q1[q1.size()-1].d);
      checkOutput("d1_cnt",   if1.bubble_cnt, mcnt1);
      checkOutput("d2_valid", if2.valid_out,  q2[q2.size()-1].v);
      checkOutput("d2_ctrl",  if2.ctrl_out,   q2[q2.size()-1].c);
      checkOutput("d2_data",  if2.data_out,   q2[q2.size()-1].d);
      checkOutput("d2_cnt",   if2.bubble_cnt, mcnt2);
      checkOutput("d3_valid", if3.valid_out,  q3[q3.size()-1].v);
      checkOutput("d3_ctrl",  if3.ctrl_out,   q3[q3.size()-1].c);
      checkOutput("d3_data",  if3.data_out,   q3[q3.size()-1].d);
      checkOutput("d3_cnt",   if3.bubble_cnt, mcnt3);
    end
  end

  task automatic applyStimulus(input logic rst, input logic stl, input logic fls,
                               input logic bub, input logic vin, input logic [CTRL_W-1:0] ctl,
                               input logic [DATA_W-1:0] dat, input logic clr);
    reset = rst; tb_stall = stl; tb_flush = fls; tb_bubble = bub;
    tb_valid = vin; tb_ctrl = ctl; tb_data = dat; tb_clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; tb_stall = 0; tb_flush = 0; tb_bubble = 0;
    tb_valid = 0; tb_ctrl = '0; tb_data = '0; tb_clear = 0;

    // T1: reset overrides a live incoming entry
    applyStimulus(1, 0, 0, 0, 1, 16'hFFFF, 128'h55, 0);
    checking = 1;
    applyStimulus(1, 0, 0, 0, 1, 16'hFFFF, 128'h55, 0);
    checkOutput("t1_valid", if3.valid_out, 0);
    checkOutput("t1_ctrl",  if3.ctrl_out, 0);
    checkOutput("t1_data",  if1.data_out, 0);
    checkOutput("t1_cnt",   if1.bubble_cnt, 0);

    // T2: DEPTH=3 latency
    applyStimulus(0, 0, 0, 0, 1, 16'd1, 128'h11, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd2, 128'h22, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd3, 128'h33, 0);
    checkOutput("t2_ctrl1",  if3.ctrl_out, 1);
    checkOutput("t2_valid1", if3.valid_out, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'hDEAD, 128'h0, 0);
    checkOutput("t2_ctrl2",  if3.ctrl_out, 2);
    applyStimulus(0, 0, 0, 0, 0, 16'hDEAD, 128'h0, 0);
    checkOutput("t2_ctrl3",  if3.ctrl_out, 3);
    checkOutput("t2_data3",  if3.data_out, 128'h33);
    applyStimulus(0, 0, 0, 0, 0, 16'hDEAD, 128'h0, 0);
    checkOutput("t2_dead_valid", if3.valid_out, 0);
    checkOutput("t2_dead_ctrl",  if3.ctrl_out, 0);

    // T3: stall holds the DEPTH=1 stage while inputs change
    applyStimulus(0, 0, 0, 0, 1, 16'h00A5, 128'h1234, 0);
    checkOutput("t3_load", if1.ctrl_out, 16'h00A5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 16'h0100 + 16'(i), 128'(i), 0);
      checkOutput("t3_hold_ctrl",  if1.ctrl_out, 16'h00A5);
      checkOutput("t3_hold_data",  if1.data_out, 128'h1234);
      checkOutput("t3_hold_valid", if1.valid_out, 1);
    end

    // T4: flush wins over stall, data still loads
    applyStimulus(0, 0, 0, 0, 1, 16'h0F0F, 128'h77, 0);
    checkOutput("t4_pre", if1.ctrl_out, 16'h0F0F);
    applyStimulus(0, 1, 1, 0, 1, 16'h003C, 128'hBEEF, 0);
    checkOutput("t4_valid", if1.valid_out, 0);
    checkOutput("t4_ctrl",  if1.ctrl_out, 0);
    checkOutput("t4_data",  if1.data_out, 128'hBEEF);

    // T5: bubble inserted on the cycle ctrl 8 is presented, DEPTH=2
    applyStimulus(0, 0, 0, 0, 1, 16'd7, 128'h7, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'd8, 128'h8, 0);
    checkOutput("t5_first", if2.ctrl_out, 7);
    applyStimulus(0, 0, 0, 0, 1, 16'd9, 128'h9, 0);
    checkOutput("t5_bub_valid", if2.valid_out, 0);
    checkOutput("t5_bub_ctrl",  if2.ctrl_out, 0);
    checkOutput("t5_bub_data",  if2.data_out, 128'h8);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 0);
    checkOutput("t5_third", if2.ctrl_out, 9);
    checkOutput("t5_third_valid", if2.valid_out, 1);

    // T6: 4-bit counter saturation and clear
    for (int i = 0; i < 23; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 0);
    checkOutput("t6_sat_d1", if1.bubble_cnt, 15);
    checkOutput("t6_sat_d3", if3.bubble_cnt, 15);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 1);
    checkOutput("t6_clear", if1.bubble_cnt, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 0);
    checkOutput("t6_resume1", if1.bubble_cnt, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 0);
    checkOutput("t6_resume2", if1.bubble_cnt, 2);

    // T7: mixed traffic, then a mid-stream reset discards in-flight entries
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, (i % 5) == 3, (i % 7) == 5, (i % 4) == 1, (i % 3) != 2,
                    16'h1000 + 16'(i), 128'hA000 + 128'(i), 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 16'hAAAA, 128'hA, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'hBBBB, 128'hB, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'hCCCC, 128'hC, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 0);
    checkOutput("t7_reset_valid", if3.valid_out, 0);
    checkOutput("t7_reset_ctrl",  if3.ctrl_out, 0);
    checkOutput("t7_reset_cnt",   if3.bubble_cnt, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 128'h0, 0);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
